// File: rtl/breath_pkg.sv
// Shared constants, FSM state type and linear duty mapping for the breathing duty generator.
// Optional BREATH_GAMMA_EN (see breath_duty_gen) selects the squared mapping instead.
package breath_pkg;

  localparam int unsigned DUTY_W         = 16;
  localparam int unsigned LEVEL_W        = 8;
  localparam logic [LEVEL_W-1:0] LEVEL_MAX = 8'd255;
  localparam int unsigned DEF_CLK_DIV    = 12000;
  localparam int unsigned DEF_HOLD_TICKS = 200;

  typedef enum logic [1:0] {
    RISE      = 2'd0,
    HIGH_HOLD = 2'd1,
    FALL      = 2'd2,
    LOW_HOLD  = 2'd3
  } breath_state_e;

  function automatic logic [DUTY_W-1:0] lin_duty(input logic [LEVEL_W-1:0] level);
    return {level, 8'h00};
  endfunction

endpackage

// File: rtl/breath_duty_gen_tick_gen.sv
// Update-tick divider: one-cycle tick every CLK_DIV enabled clocks; en=0 clears the count.
module tick_gen
  import breath_pkg::*;
#(
  parameter int unsigned CLK_DIV = DEF_CLK_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int unsigned CNT_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] count;

  assign tick = en && (count == LAST);

  always_ff @(posedge clk) begin
    if (rst || !en || tick) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/breath_duty_gen.sv
// Breathing LED duty generator: triangular 8-bit level ramp with end holds, valid/ready output.
// Define BREATH_GAMMA_EN for a squared (gamma) duty mapping with one extra pipeline stage.
module breath_duty_gen
  import breath_pkg::*;
#(
  parameter int unsigned CLK_DIV    = DEF_CLK_DIV,
  parameter int unsigned HOLD_TICKS = DEF_HOLD_TICKS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  output logic [DUTY_W-1:0] duty_out,
  output logic              duty_valid,
  input  logic              duty_ready,
  output logic [7:0]        overrun_cnt
);

  localparam int unsigned HOLD_W = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((HOLD_TICKS > 0) ? HOLD_TICKS - 1 : 0);

  logic                tick;
  breath_state_e       state, state_nxt;
  logic [LEVEL_W-1:0]  level, level_nxt;
  logic [HOLD_W-1:0]   hold_cnt, hold_nxt;
  logic                new_val;
  logic [DUTY_W-1:0]   new_duty;

  tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .tick (tick)
  );

  always_comb begin
    state_nxt = state;
    level_nxt = level;
    hold_nxt  = hold_cnt;
    case (state)
      RISE: begin
        level_nxt = level + 8'd1;
        if (level_nxt == LEVEL_MAX) begin
          hold_nxt = '0;
          if (HOLD_TICKS == 0) state_nxt = FALL;
          else                 state_nxt = HIGH_HOLD;
        end
      end
      HIGH_HOLD: begin
        if (hold_cnt == HOLD_LAST) state_nxt = FALL;
        else                       hold_nxt  = hold_cnt + 1'b1;
      end
      FALL: begin
        level_nxt = level - 8'd1;
        if (level_nxt == '0) begin
          hold_nxt = '0;
          if (HOLD_TICKS == 0) state_nxt = RISE;
          else                 state_nxt = LOW_HOLD;
        end
      end
      LOW_HOLD: begin
        if (hold_cnt == HOLD_LAST) state_nxt = RISE;
        else                       hold_nxt  = hold_cnt + 1'b1;
      end
      default: state_nxt = RISE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RISE;
      level    <= '0;
      hold_cnt <= '0;
    end else if (tick) begin
      state    <= state_nxt;
      level    <= level_nxt;
      hold_cnt <= hold_nxt;
    end
  end

`ifdef BREATH_GAMMA_EN
  // Square the already-registered level one cycle after the tick; level is stable then
  // because ticks are at least two cycles apart.
  logic tick_d;

  always_ff @(posedge clk) begin
    if (rst) tick_d <= 1'b0;
    else     tick_d <= tick;
  end

  assign new_val  = tick_d;
  assign new_duty = DUTY_W'(level) * DUTY_W'(level);
`else
  assign new_val  = tick;
  assign new_duty = lin_duty(level_nxt);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      duty_out    <= '0;
      duty_valid  <= 1'b0;
      overrun_cnt <= '0;
    end else if (new_val) begin
      duty_out   <= new_duty;
      duty_valid <= 1'b1;
      if (duty_valid && !duty_ready && (overrun_cnt != 8'hFF))
        overrun_cnt <= overrun_cnt + 8'd1;
    end else if (duty_valid && duty_ready) begin
      duty_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_breath_duty_gen.sv
// Self-checking bench for breath_duty_gen: HOLD_TICKS=2 and HOLD_TICKS=0 instances, CLK_DIV=4.
// Honours BREATH_GAMMA_EN for the expected mapping and latency.
`timescale 1ns/1ps
module tb_breath_duty_gen;

  localparam int unsigned CLK_DIV = 4;
`ifdef BREATH_GAMMA_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        ready = 1'b1;
  logic [15:0] duty_a, duty_b;
  logic        valid_a, valid_b;
  logic [7:0]  ovr_a, ovr_b;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  breath_duty_gen #(.CLK_DIV(CLK_DIV), .HOLD_TICKS(2)) dut_a (
    .clk(clk), .rst(rst), .en(en), .duty_out(duty_a), .duty_valid(valid_a),
    .duty_ready(ready), .overrun_cnt(ovr_a)
  );

  breath_duty_gen #(.CLK_DIV(CLK_DIV), .HOLD_TICKS(0)) dut_b (
    .clk(clk), .rst(rst), .en(en), .duty_out(duty_b), .duty_valid(valid_b),
    .duty_ready(ready), .overrun_cnt(ovr_b)
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Level produced by the k-th tick after reset (k >= 1), from the ramp/hold rules.
  function automatic int level_at(input int k, input int h);
    int p;
    p = (k - 1) % (510 + 2 * h);
    if (p < 255) return p + 1;
    p -= 255;
    if (p < h) return 255;
    p -= h;
    if (p < 255) return 254 - p;
    return 0;
  endfunction

  function automatic int map(input int l);
`ifdef BREATH_GAMMA_EN
    return l * l;
`else
    return l * 256;
`endif
  endfunction

  function automatic int hold_of(input int i);
    return (i == 0) ? 2 : 0;
  endfunction

  // Reference model: tick index from enabled-cycle counting, output slot with overrun rules.
  int m_cnt, m_ticks;
  bit m_started = 1'b0;
  bit m_pend[2];
  int m_pval[2];
  bit m_valid[2];
  int m_duty[2];
  int m_ovr[2];

  always @(posedge clk) begin
    bit tk;
    bit nv;
    int val;
    tk = 1'b0;
    if (rst) begin
      m_cnt = 0;
      m_ticks = 0;
      m_started = 1'b1;
      for (int i = 0; i < 2; i++) begin
        m_pend[i] = 1'b0; m_pval[i] = 0; m_valid[i] = 1'b0; m_duty[i] = 0; m_ovr[i] = 0;
      end
    end else begin
      if (en) begin
        m_cnt++;
        if (m_cnt == CLK_DIV) begin
          m_cnt = 0;
          m_ticks++;
          tk = 1'b1;
        end
      end else begin
        m_cnt = 0;
      end
      for (int i = 0; i < 2; i++) begin
        if (LAT == 1) begin
          nv  = tk;
          val = tk ? map(level_at(m_ticks, hold_of(i))) : 0;
        end else begin
          nv  = m_pend[i];
          val = m_pval[i];
          m_pend[i] = tk;
          if (tk) m_pval[i] = map(level_at(m_ticks, hold_of(i)));
        end
        if (nv) begin
          if (m_valid[i] && !ready && m_ovr[i] < 255) m_ovr[i]++;
          m_duty[i]  = val;
          m_valid[i] = 1'b1;
        end else if (m_valid[i] && ready) begin
          m_valid[i] = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_started) begin
      check("duty_a",  int'(duty_a),  m_duty[0]);
      check("valid_a", int'(valid_a), int'(m_valid[0]));
      check("ovr_a",   int'(ovr_a),   m_ovr[0]);
      check("duty_b",  int'(duty_b),  m_duty[1]);
      check("valid_b", int'(valid_b), int'(m_valid[1]));
      check("ovr_b",   int'(ovr_b),   m_ovr[1]);
    end
  end

  // End-of-ramp turnarounds of the no-hold instance, watched while ready stays high.
  bit seq_watch = 1'b0;
  int last_b = -1;

  always @(negedge clk) begin
    if (seq_watch && valid_b) begin
      if (last_b == map(255)) check("nohold_top", int'(duty_b), map(254));
      if (last_b == map(0) && last_b >= 0) check("nohold_bottom", int'(duty_b), map(1));
      last_b = int'(duty_b);
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    en  = 1'b0;
    ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_duty",  int'(duty_a),  0);
    check("rst_valid", int'(valid_a), 0);
    check("rst_ovr",   int'(ovr_a),   0);
    rst = 1'b0;
  endtask

  task automatic wait_valid(input string name, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!valid_a && n < 40);
    if (!valid_a) check({name, "_timeout"}, 0, 1);
  endtask

  initial begin
    int n;
    int guard;

    check("model_k1",     level_at(1, 2),   1);
    check("model_k255",   level_at(255, 2), 255);
    check("model_k257",   level_at(257, 2), 255);
    check("model_k258",   level_at(258, 2), 254);
    check("model_k514",   level_at(514, 2), 0);
    check("model_k515",   level_at(515, 2), 1);
    check("model_h0_256", level_at(256, 0), 254);
    check("model_h0_511", level_at(511, 0), 1);

    // First value: valid in the 5th cycle counting the release cycle (4 edges), plus gamma stage.
    do_reset();
    en = 1'b1;
    wait_valid("first", n);
    check("first_latency", n, 3 + LAT);
`ifdef BREATH_GAMMA_EN
    check("first_duty", int'(duty_a), 1);
`else
    check("first_duty", int'(duty_a), 16'h0100);
`endif

    seq_watch = 1'b1;
    repeat (520 * CLK_DIV) @(negedge clk);
    seq_watch = 1'b0;

    // Freeze at level 100, then resume.
    do_reset();
    en = 1'b1;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!(valid_a && duty_a == 16'(map(100))) && guard < 1000);
    check("reach_100", int'(duty_a), map(100));
    en = 1'b0;
    repeat (50) @(negedge clk);
`ifdef BREATH_GAMMA_EN
    check("freeze_duty", int'(duty_a), 10000);
`else
    check("freeze_duty", int'(duty_a), 16'h6400);
`endif
    check("freeze_valid", int'(valid_a), 0);
    en = 1'b1;
    wait_valid("resume", n);
    check("resume_latency", n, 3 + LAT);
`ifdef BREATH_GAMMA_EN
    check("resume_duty", int'(duty_a), 10201);
`else
    check("resume_duty", int'(duty_a), 16'h6500);
`endif

    // Backpressure: three unaccepted values, then acceptance coinciding with a new value.
    do_reset();
    en = 1'b1;
    wait_valid("ovr_start", n);
    @(negedge clk);
    ready = 1'b0;
    repeat (11) @(negedge clk);
    check("ovr_cnt2",   int'(ovr_a),   2);
    check("ovr_valid",  int'(valid_a), 1);
`ifdef BREATH_GAMMA_EN
    check("ovr_latest", int'(duty_a), 16);
`else
    check("ovr_latest", int'(duty_a), 16'h0400);
`endif
    repeat (3) @(negedge clk);
    ready = 1'b1;
    @(negedge clk);
    check("simul_cnt",   int'(ovr_a),   2);
    check("simul_valid", int'(valid_a), 1);
`ifdef BREATH_GAMMA_EN
    check("simul_duty", int'(duty_a), 25);
`else
    check("simul_duty", int'(duty_a), 16'h0500);
`endif
    @(negedge clk);
    check("accept_drop", int'(valid_a), 0);

    ready = 1'b0;
    repeat (262 * CLK_DIV) @(negedge clk);
    check("ovr_saturate", int'(ovr_a), 255);
    ready = 1'b1;
    repeat (8) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
